// File: rtl/pipe_decode_stage.sv
// Y86-64 decode stage: register file, source/destination decode, operand forwarding,
// load-use hazard detection and the D/E pipeline register. Optional macro: PIPE_DECODE_FWD_EN.
module pipe_decode_stage #(
    parameter int                DATA_W   = 64,
    parameter int                NREG     = 15,
    parameter logic [DATA_W-1:0] RSP_INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [3:0]        in_icode,
    input  logic [3:0]        in_ifun,
    input  logic [3:0]        in_rA,
    input  logic [3:0]        in_rB,
    input  logic [DATA_W-1:0] in_valC,
    input  logic [DATA_W-1:0] in_valP,
    output logic              in_ready,
    input  logic              flush,
    input  logic              e_stall,
    input  logic [3:0]        e_dstE,
    input  logic [3:0]        e_dstM,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [3:0]        m_dstE,
    input  logic [3:0]        m_dstM,
    input  logic [DATA_W-1:0] m_valE,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [3:0]        w_dstE,
    input  logic [3:0]        w_dstM,
    input  logic [DATA_W-1:0] w_valE,
    input  logic [DATA_W-1:0] w_valM,
    output logic              out_valid,
    output logic [3:0]        out_icode,
    output logic [3:0]        out_ifun,
    output logic [DATA_W-1:0] out_valA,
    output logic [DATA_W-1:0] out_valB,
    output logic [DATA_W-1:0] out_valC,
    output logic [DATA_W-1:0] out_valP,
    output logic [3:0]        out_srcA,
    output logic [3:0]        out_srcB,
    output logic [3:0]        out_dstE,
    output logic [3:0]        out_dstM
);
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    typedef struct packed {
        logic              valid;
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [DATA_W-1:0] val_a;
        logic [DATA_W-1:0] val_b;
        logic [DATA_W-1:0] val_c;
        logic [DATA_W-1:0] val_p;
        logic [3:0]        src_a;
        logic [3:0]        src_b;
        logic [3:0]        dst_e;
        logic [3:0]        dst_m;
    } de_t;

    de_t               de_q, de_d;
    logic [DATA_W-1:0] rf_q [NREG];
    logic [DATA_W-1:0] rf_d [NREG];
    logic [3:0]        src_a, src_b, dst_e, dst_m;
    logic [DATA_W-1:0] val_a, val_b;
    logic              hazard;

    function automatic de_t bubble();
        de_t b;
        b       = '0;
        b.icode = 4'h1;
        b.src_a = RNONE;
        b.src_b = RNONE;
        b.dst_e = RNONE;
        b.dst_m = RNONE;
        return b;
    endfunction

    function automatic logic [DATA_W-1:0] rf_read(input logic [3:0] id);
        if (int'(id) < NREG)
            return rf_q[id];
        return '0;
    endfunction

    function automatic logic [DATA_W-1:0] operand(input logic [3:0] src);
        logic [DATA_W-1:0] v;
        v = rf_read(src);
`ifdef PIPE_DECODE_FWD_EN
        if (src != RNONE) begin
            if (src == e_dstE)      v = e_valE;
            else if (src == m_dstM) v = m_valM;
            else if (src == m_dstE) v = m_valE;
            else if (src == w_dstM) v = w_valM;
            else if (src == w_dstE) v = w_valE;
        end
`else
        // Write-before-read: a same-cycle W write is seen by the read port.
        if (int'(src) < NREG) begin
            if (src == w_dstM)      v = w_valM;
            else if (src == w_dstE) v = w_valE;
        end
`endif
        return v;
    endfunction

    function automatic logic dst_hit(input logic [3:0] src);
`ifdef PIPE_DECODE_FWD_EN
        return (src != RNONE) && (src == e_dstM);
`else
        return (src != RNONE) &&
               ((src == e_dstE) || (src == e_dstM) || (src == m_dstE) || (src == m_dstM));
`endif
    endfunction

`ifndef PIPE_DECODE_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{e_valE, m_valE, m_valM};
`endif

    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (in_icode)
            4'h2: begin src_a = in_rA; dst_e = in_rB; end
            4'h3: dst_e = in_rB;
            4'h4: begin src_a = in_rA; src_b = in_rB; end
            4'h5: begin src_b = in_rB; dst_m = in_rA; end
            4'h6: begin src_a = in_rA; src_b = in_rB; dst_e = in_rB; end
            4'h8: begin src_b = RSP; dst_e = RSP; end
            4'h9: begin src_a = RSP; src_b = RSP; dst_e = RSP; end
            4'hA: begin src_a = in_rA; src_b = RSP; dst_e = RSP; end
            4'hB: begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = in_rA; end
            default: ;
        endcase
    end

    always_comb begin
        val_a    = ((in_icode == 4'h7) || (in_icode == 4'h8)) ? in_valP : operand(src_a);
        val_b    = operand(src_b);
        hazard   = in_valid & (dst_hit(src_a) | dst_hit(src_b));
        in_ready = flush | (~e_stall & ~hazard);
    end

    always_comb begin
        de_d = de_q;
        if (flush) begin
            de_d = bubble();
        end else if (!e_stall) begin
            if (hazard || !in_valid) begin
                de_d = bubble();
            end else begin
                de_d.valid = 1'b1;
                de_d.icode = in_icode;
                de_d.ifun  = in_ifun;
                de_d.val_a = val_a;
                de_d.val_b = val_b;
                de_d.val_c = in_valC;
                de_d.val_p = in_valP;
                de_d.src_a = src_a;
                de_d.src_b = src_b;
                de_d.dst_e = dst_e;
                de_d.dst_m = dst_m;
            end
        end
    end

    // valM is written second so it wins when both W ports target the same register.
    always_comb begin
        rf_d = rf_q;
        if (int'(w_dstE) < NREG) rf_d[w_dstE] = w_valE;
        if (int'(w_dstM) < NREG) rf_d[w_dstM] = w_valM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_q <= bubble();
            for (int i = 0; i < NREG; i++)
                rf_q[i] <= (i == 4) ? RSP_INIT : '0;
        end else begin
            de_q <= de_d;
            rf_q <= rf_d;
        end
    end

    assign out_valid = de_q.valid;
    assign out_icode = de_q.icode;
    assign out_ifun  = de_q.ifun;
    assign out_valA  = de_q.val_a;
    assign out_valB  = de_q.val_b;
    assign out_valC  = de_q.val_c;
    assign out_valP  = de_q.val_p;
    assign out_srcA  = de_q.src_a;
    assign out_srcB  = de_q.src_b;
    assign out_dstE  = de_q.dst_e;
    assign out_dstM  = de_q.dst_m;
endmodule
